// File: rtl/snake_engine.sv
// ---------------------------------------------------------------------------
// snake_engine
//
// Snake-body engine for the grid game. It owns the head position, the travel
// direction, the body length and a circular buffer of body segments. Each
// accepted step either commits a new head cell or kills the snake. A step
// kills the snake when the new head would leave the grid or would land on a
// body segment. Body segments are checked one per clock.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   step       single-cycle move request, only honoured while idle and alive
//   di         requested direction: 0 up, 1 down, 2 left, 3 right
//   grow       single-cycle growth request (food eaten)
//   rd_idx     segment index for the renderer read port, 0 = head
//   rd_x/rd_y  registered segment coordinates (0 when rd_idx >= len)
//   rd_valid   registered, 1 when rd_idx < len
//   head_x/y   committed head position
//   len        committed body length
//   alive      drops to 0 once a wall or self collision is detected
//   busy       1 while a step is being scanned or committed
//   step_done  one-cycle pulse when a step resolves (commit or death)
//
// Build option
//   SNAKE_WRAP_EN  when defined, the head wraps around the grid edges instead
//                  of dying at a wall.
// ---------------------------------------------------------------------------
module snake_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int XW       = 5,
    parameter int YW       = 5,
    parameter int MAX_LEN  = 64,
    parameter int LW       = 7,
    parameter int INIT_LEN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [1:0]    di,
    input  logic          grow,
    input  logic [LW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] len,
    output logic          alive,
    output logic          busy,
    output logic          step_done
);

    // Width of a physical slot number in the circular segment buffer.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam int CX = GRID_W / 2;
    localparam int CY = GRID_H / 2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
    localparam logic [LW:0]   DEPTH    = (LW + 1)'(MAX_LEN);
    localparam logic [AW-1:0] SLOT_TOP = AW'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        COMMIT,
        DEAD
    } state_t;

    state_t        state;
    logic [1:0]    dir;
    logic [AW-1:0] hp;
    logic          grow_pend;
    logic          grow_now;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic [LW-1:0] scan_idx;
    logic [LW-1:0] scan_last;

    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];

    logic [1:0]    new_dir;
    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;
    logic          at_edge;
    logic          off_grid;
    logic          accept;
    logic          gn;
    logic          hit;
    logic [AW-1:0] scan_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] hp_dec;

    // Logical segment i lives in physical slot (hp + i) mod MAX_LEN. The
    // offset may exceed the body length on the read port; those results are
    // never used, but they are clamped so that the array index stays legal.
    function automatic logic [AW-1:0] slot(input logic [AW-1:0] base,
                                           input logic [LW-1:0] off);
        logic [LW:0] sum;
        sum = {{(LW + 1 - AW){1'b0}}, base} + {1'b0, off};
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        if (sum >= DEPTH) begin
            sum = '0;
        end
        return sum[AW-1:0];
    endfunction

    // A step is taken only from IDLE. Growth for this step combines the
    // sticky request with a same-cycle pulse. Growth is suppressed once the
    // buffer is full so that the length can never exceed MAX_LEN.
    assign accept    = (state == IDLE) && step;
    assign gn        = (grow_pend | grow) && (len != LEN_MAX);
    assign scan_addr = slot(hp, scan_idx);
    assign rd_addr   = slot(hp, rd_idx);
    assign hit       = (seg_x[scan_addr] == cand_x) && (seg_y[scan_addr] == cand_y);
    assign hp_dec    = (hp == '0) ? SLOT_TOP : hp - AW'(1);

    // Work out the next head cell from the requested direction. A request
    // for the exact opposite of the current heading is ignored, because the
    // snake would otherwise turn back into its own neck. The candidate is
    // always computed with wrap-around. at_edge records whether a wrap
    // happened, and the wall logic below decides what that means.
    always_comb begin
        new_dir = (di == (dir ^ 2'b01)) ? dir : di;
        nxt_x   = head_x;
        nxt_y   = head_y;
        at_edge = 1'b0;
        unique case (new_dir)
            DIR_UP: begin
                at_edge = (head_y == '0);
                nxt_y   = at_edge ? Y_MAX : head_y - YW'(1);
            end
            DIR_DOWN: begin
                at_edge = (head_y == Y_MAX);
                nxt_y   = at_edge ? '0 : head_y + YW'(1);
            end
            DIR_LEFT: begin
                at_edge = (head_x == '0);
                nxt_x   = at_edge ? X_MAX : head_x - XW'(1);
            end
            DIR_RIGHT: begin
                at_edge = (head_x == X_MAX);
                nxt_x   = at_edge ? '0 : head_x + XW'(1);
            end
        endcase
    end

    // With wrapping enabled, the wrapped candidate is a legal move. Without
    // it, crossing an edge is fatal.
`ifdef SNAKE_WRAP_EN
    assign off_grid = 1'b0;
`else
    assign off_grid = at_edge;
`endif

    // Main engine: the step FSM, the body buffer, the sticky growth flag and
    // the registered read port, all in one clocked block. The read port
    // samples committed state, so a read issued during COMMIT still returns
    // the body as it was before the step. In CHECK, one logical index is
    // compared per cycle from the head towards the tail. The tail slot is
    // skipped on a non-growing step, because the tail moves out of that cell
    // in the same commit. COMMIT moves the head pointer back one slot and
    // writes the candidate there. That implicitly drops the old tail when the
    // length does not grow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= DIR_RIGHT;
            hp        <= '0;
            len       <= LEN_INIT;
            head_x    <= XW'(CX);
            head_y    <= YW'(CY);
            alive     <= 1'b1;
            busy      <= 1'b0;
            step_done <= 1'b0;
            grow_pend <= 1'b0;
            grow_now  <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
            scan_idx  <= '0;
            scan_last <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_valid  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? XW'(CX - i) : '0;
                seg_y[i] <= (i < INIT_LEN) ? YW'(CY) : '0;
            end
        end else begin
            step_done <= 1'b0;

            rd_valid <= (rd_idx < len);
            rd_x     <= (rd_idx < len) ? seg_x[rd_addr] : '0;
            rd_y     <= (rd_idx < len) ? seg_y[rd_addr] : '0;

            if (!accept && grow && (len != LEN_MAX)) begin
                grow_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (step) begin
                        dir       <= new_dir;
                        grow_pend <= 1'b0;
                        grow_now  <= gn;
                        cand_x    <= nxt_x;
                        cand_y    <= nxt_y;
                        if (off_grid) begin
                            state     <= DEAD;
                            alive     <= 1'b0;
                            step_done <= 1'b1;
                        end else begin
                            state     <= CHECK;
                            busy      <= 1'b1;
                            scan_idx  <= '0;
                            scan_last <= gn ? len - LW'(1) : len - LW'(2);
                        end
                    end
                end
                CHECK: begin
                    if (hit) begin
                        state     <= DEAD;
                        alive     <= 1'b0;
                        busy      <= 1'b0;
                        step_done <= 1'b1;
                    end else if (scan_idx == scan_last) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + LW'(1);
                    end
                end
                COMMIT: begin
                    hp            <= hp_dec;
                    seg_x[hp_dec] <= cand_x;
                    seg_y[hp_dec] <= cand_y;
                    head_x        <= cand_x;
                    head_y        <= cand_y;
                    len           <= len + LW'(grow_now);
                    busy          <= 1'b0;
                    step_done     <= 1'b1;
                    state         <= IDLE;
                end
                DEAD: begin
                    alive <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// ---------------------------------------------------------------------------
// tb_snake_engine
//
// Self-checking bench for snake_engine with the default parameters. The
// reference model keeps the body as a queue of cells with the head at the
// front. It resolves each accepted step at once: it finds the wall or the
// first colliding body cell, and from that the cycle in which the result
// must appear. A compare process checks every DUT output against the model
// after every clock edge. Directed scenarios add literal expectations.
// Randomized phases follow: a long growth run around a loop path, then
// random play with random resets.
// ---------------------------------------------------------------------------
module tb_snake_engine;

    localparam int GRID_W   = 32;
    localparam int GRID_H   = 24;
    localparam int XW       = 5;
    localparam int YW       = 5;
    localparam int MAX_LEN  = 64;
    localparam int LW       = 7;
    localparam int INIT_LEN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic [1:0]    di = 2'd0;
    logic          grow = 1'b0;
    logic [LW-1:0] rd_idx = '0;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_valid;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] len;
    logic          alive;
    logic          busy;
    logic          step_done;

    snake_engine #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
        .MAX_LEN(MAX_LEN), .LW(LW), .INIT_LEN(INIT_LEN)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .di(di), .grow(grow),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .head_x(head_x), .head_y(head_y), .len(len), .alive(alive),
        .busy(busy), .step_done(step_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x;
        int y;
    } cell_t;

    cell_t body[$];
    int    m_dir;
    bit    m_alive;
    bit    m_pend;
    bit    in_flight;
    int    done_cycle;
    int    cyc;
    bit    o_dead;
    bit    o_grow;
    cell_t o_cand;
    bit    model_valid = 1'b0;
    bit    exp_busy;
    bit    exp_step_done;
    bit    exp_rd_valid;
    int    exp_rd_x;
    int    exp_rd_y;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Put the model into the reset state: a horizontal body centred on the
    // grid, heading right.
    task automatic modelReset();
        cell_t c;
        body.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            c.x = GRID_W / 2 - i;
            c.y = GRID_H / 2;
            body.push_back(c);
        end
        m_dir         = 3;
        m_alive       = 1'b1;
        m_pend        = 1'b0;
        in_flight     = 1'b0;
        exp_busy      = 1'b0;
        exp_step_done = 1'b0;
        exp_rd_valid  = 1'b0;
        exp_rd_x      = 0;
        exp_rd_y      = 0;
        cyc           = 0;
        model_valid   = 1'b1;
    endtask

    // Reference model, advanced once per clock edge. Inputs change on the
    // falling edge, so they are stable here. When a step is accepted, the
    // model decides its whole outcome at once: wall, first hit index, or
    // commit. It stores that outcome together with the absolute cycle in
    // which the outcome must become visible.
    always @(posedge clk) begin
        cell_t cand;
        int    n;
        int    hit_k;
        int    lat;
        bit    gn;
        bit    wall;
        if (rst) begin
            modelReset();
        end else if (model_valid) begin
            cyc++;
            exp_rd_valid  = (rd_idx < body.size());
            exp_rd_x      = exp_rd_valid ? body[rd_idx].x : 0;
            exp_rd_y      = exp_rd_valid ? body[rd_idx].y : 0;
            exp_step_done = 1'b0;
            exp_busy      = 1'b0;
            if (!in_flight && step && m_alive) begin
                gn     = (m_pend || grow) && (body.size() < MAX_LEN);
                m_pend = 1'b0;
                if (!((int'(di) == 0 && m_dir == 1) || (int'(di) == 1 && m_dir == 0) ||
                      (int'(di) == 2 && m_dir == 3) || (int'(di) == 3 && m_dir == 2))) begin
                    m_dir = int'(di);
                end
                cand = body[0];
                case (m_dir)
                    0: cand.y = cand.y - 1;
                    1: cand.y = cand.y + 1;
                    2: cand.x = cand.x - 1;
                    default: cand.x = cand.x + 1;
                endcase
`ifdef SNAKE_WRAP_EN
                cand.x = (cand.x + GRID_W) % GRID_W;
                cand.y = (cand.y + GRID_H) % GRID_H;
                wall   = 1'b0;
`else
                wall = (cand.x < 0) || (cand.x >= GRID_W) || (cand.y < 0) || (cand.y >= GRID_H);
`endif
                if (wall) begin
                    lat    = 1;
                    o_dead = 1'b1;
                end else begin
                    n     = gn ? body.size() : body.size() - 1;
                    hit_k = -1;
                    for (int k = 0; k < n; k++) begin
                        if (hit_k < 0 && body[k].x == cand.x && body[k].y == cand.y) begin
                            hit_k = k;
                        end
                    end
                    o_dead = (hit_k >= 0);
                    lat    = o_dead ? hit_k + 2 : n + 2;
                end
                o_cand     = cand;
                o_grow     = gn;
                in_flight  = 1'b1;
                done_cycle = cyc + lat - 1;
            end else if (grow && body.size() < MAX_LEN) begin
                m_pend = 1'b1;
            end
            if (in_flight) begin
                if (cyc == done_cycle) begin
                    in_flight     = 1'b0;
                    exp_step_done = 1'b1;
                    if (o_dead) begin
                        m_alive = 1'b0;
                    end else begin
                        body.push_front(o_cand);
                        if (!o_grow) begin
                            void'(body.pop_back());
                        end
                    end
                end else begin
                    exp_busy = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output with the model shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            checkOutput("busy", int'(busy), int'(exp_busy));
            checkOutput("step_done", int'(step_done), int'(exp_step_done));
            checkOutput("alive", int'(alive), int'(m_alive));
            checkOutput("len", int'(len), body.size());
            checkOutput("head_x", int'(head_x), body[0].x);
            checkOutput("head_y", int'(head_y), body[0].y);
            checkOutput("rd_valid", int'(rd_valid), int'(exp_rd_valid));
            checkOutput("rd_x", int'(rd_x), exp_rd_x);
            checkOutput("rd_y", int'(rd_y), exp_rd_y);
        end
    end

    task automatic applyStimulus(input bit s, input logic [1:0] d, input bit g,
                                 input logic [LW-1:0] r);
        @(negedge clk);
        step   = s;
        di     = d;
        grow   = g;
        rd_idx = r;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst  = 1'b1;
        step = 1'b0;
        grow = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one step and count the cycles until step_done. Optionally, raise
    // step again in the first busy cycle; that request must be ignored.
    task automatic doStep(input logic [1:0] d, input bit g, input bit poke, input int exp_lat);
        int cycles;
        applyStimulus(1'b1, d, g, rd_idx);
        cycles = 0;
        do begin
            @(negedge clk);
            step = poke && (cycles == 0);
            grow = 1'b0;
            cycles++;
        end while (!step_done && cycles < 300);
        step = 1'b0;
        checkOutput("step latency", cycles, exp_lat);
    endtask

    task automatic readCheck(input int idx, input int ex, input int ey, input int ev);
        applyStimulus(1'b0, 2'd0, 1'b0, LW'(idx));
        @(negedge clk);
        checkOutput("rd_valid lit", int'(rd_valid), ev);
        checkOutput("rd_x lit", int'(rd_x), ex);
        checkOutput("rd_y lit", int'(rd_y), ey);
    endtask

    task automatic headCheck(input int ex, input int ey, input int el, input int ea);
        checkOutput("head_x lit", int'(head_x), ex);
        checkOutput("head_y lit", int'(head_y), ey);
        checkOutput("len lit", int'(len), el);
        checkOutput("alive lit", int'(alive), ea);
    endtask

    // Clockwise loop well inside the grid. Its perimeter exceeds MAX_LEN, so
    // a snake following it never meets its own body.
    function automatic logic [1:0] loopDir(input int x, input int y);
        if (y == 2 && x < 29) return 2'd3;
        if (x == 29 && y < 21) return 2'd1;
        if (y == 21 && x > 2) return 2'd2;
        if (x == 2 && y > 2) return 2'd0;
        return 2'd3;
    endfunction

    initial begin
        int guard;
        int cnt;
        int seen;

        // Reset state, then a plain move to the right.
        doReset();
        headCheck(16, 12, 3, 1);
        checkOutput("busy after reset", int'(busy), 0);
        checkOutput("rd_valid after reset", int'(rd_valid), 0);
        doStep(2'd3, 1'b0, 1'b0, 4);
        headCheck(17, 12, 3, 1);
        readCheck(2, 15, 12, 1);
        readCheck(3, 0, 0, 0);

        // Deferred growth: the grow pulse comes before the step.
        doReset();
        applyStimulus(1'b0, 2'd0, 1'b1, '0);
        doStep(2'd3, 1'b0, 1'b0, 5);
        headCheck(17, 12, 4, 1);
        readCheck(3, 14, 12, 1);

        // Reversal rejected, and a step while busy is dropped.
        doStep(2'd2, 1'b0, 1'b1, 5);
        repeat (8) applyStimulus(1'b0, 2'd0, 1'b0, '0);
        headCheck(18, 12, 4, 1);

        // Grow to length 5, then up, left, down hits body index 3.
        doStep(2'd3, 1'b1, 1'b0, 6);
        headCheck(19, 12, 5, 1);
        doStep(2'd0, 1'b0, 1'b0, 6);
        doStep(2'd2, 1'b0, 1'b0, 6);
        headCheck(18, 11, 5, 1);
        doStep(2'd1, 1'b0, 1'b0, 5);
        headCheck(18, 11, 5, 0);
        applyStimulus(1'b1, 2'd3, 1'b0, '0);
        repeat (4) applyStimulus(1'b0, 2'd0, 1'b0, '0);
        checkOutput("busy when dead", int'(busy), 0);
        headCheck(18, 11, 5, 0);

        // The same turn sequence at length 4 survives, because the tail cell
        // is vacated by the step.
        doReset();
        doStep(2'd3, 1'b1, 1'b0, 5);
        doStep(2'd0, 1'b0, 1'b0, 5);
        doStep(2'd2, 1'b0, 1'b0, 5);
        doStep(2'd1, 1'b0, 1'b0, 5);
        headCheck(16, 12, 4, 1);

        // Right wall.
        doReset();
        repeat (15) doStep(2'd3, 1'b0, 1'b0, 4);
        headCheck(31, 12, 3, 1);
`ifdef SNAKE_WRAP_EN
        doStep(2'd3, 1'b0, 1'b0, 4);
        headCheck(0, 12, 3, 1);
`else
        doStep(2'd3, 1'b0, 1'b0, 1);
        headCheck(31, 12, 3, 0);
`endif

        // Reset during CHECK abandons the step without any step_done pulse.
        doReset();
        applyStimulus(1'b1, 2'd3, 1'b0, '0);
        @(negedge clk);
        step = 1'b0;
        checkOutput("busy in check", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        headCheck(16, 12, 3, 1);
        checkOutput("busy after abort", int'(busy), 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (step_done) seen++;
        end
        checkOutput("no step_done after abort", seen, 0);

        // Grow to MAX_LEN along the loop with randomized grow and read
        // traffic, then ask for one more growth.
        doReset();
        guard = 0;
        while (body.size() < MAX_LEN && m_alive && guard < 250) begin
            applyStimulus(1'b1, loopDir(body[0].x, body[0].y), ($urandom_range(0, 3) != 0),
                          LW'($urandom_range(0, MAX_LEN + 8)));
            cnt = 0;
            do begin
                @(negedge clk);
                step   = 1'b0;
                grow   = ($urandom_range(0, 15) == 0);
                rd_idx = LW'($urandom_range(0, MAX_LEN + 8));
                cnt++;
            end while (in_flight && cnt < 300);
            guard++;
        end
        grow = 1'b0;
        checkOutput("len at max", int'(len), MAX_LEN);
        applyStimulus(1'b0, 2'd0, 1'b1, '0);
        doStep(loopDir(body[0].x, body[0].y), 1'b1, 1'b0, MAX_LEN + 1);
        checkOutput("len capped", int'(len), MAX_LEN);
        checkOutput("alive at max", int'(alive), 1);
        readCheck(MAX_LEN - 1, body[MAX_LEN - 1].x, body[MAX_LEN - 1].y, 1);
        readCheck(MAX_LEN, 0, 0, 0);

        // Random play with occasional resets.
        for (int round = 0; round < 6; round++) begin
            doReset();
            repeat (400) begin
                @(negedge clk);
                step   = ($urandom_range(0, 2) == 0);
                di     = 2'($urandom_range(0, 3));
                grow   = ($urandom_range(0, 7) == 0);
                rd_idx = LW'($urandom_range(0, MAX_LEN));
                rst    = ($urandom_range(0, 249) == 0) || (!m_alive && $urandom_range(0, 19) == 0);
            end
            @(negedge clk);
            step = 1'b0;
            grow = 1'b0;
            rst  = 1'b0;
        end

        repeat (4) applyStimulus(1'b0, 2'd0, 1'b0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
